// File: rtl/shift_reg_pkg.sv
// ============================================================================
// Module      : shift_reg_pkg
// Description : Mode encodings and direction constants shared by the
//               universal shift register and its per-bit cells.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    localparam logic c_DIR_LEFT  = 1'b0;
    localparam logic c_DIR_RIGHT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/shift_reg_cell.sv
// ============================================================================
// Module      : shift_reg_cell
// Description : One register bit: 4:1 mode mux feeding a synchronous-reset flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_cell
    import shift_reg_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_en,
    input  mode_t i_mode,
    input  logic  i_from_lo,
    input  logic  i_from_hi,
    input  logic  i_p,
    output logic  o_q
);

    logic r_q_q;
    logic w_q_d;

    always_comb begin
        w_q_d = r_q_q;
        if (i_en) begin
            case (i_mode)
                MODE_SHL:  w_q_d = i_from_lo;
                MODE_SHR:  w_q_d = i_from_hi;
                MODE_LOAD: w_q_d = i_p;
                default:   w_q_d = r_q_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q_q <= 1'b0;
        end else begin
            r_q_q <= w_q_d;
        end
    end

    assign o_q = r_q_q;

endmodule

`default_nettype wire

// File: rtl/shift_reg_univ.sv
// ============================================================================
// Module      : shift_reg_univ
// Description : Universal shift register with per-direction word counter and
//               a one-cycle word-complete strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic             i_d,
    input  logic [WIDTH-1:0] i_p,
    output logic [WIDTH-1:0] o_q,
    output logic             o_sout_l,
    output logic             o_sout_r,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_word_vld
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    mode_t            w_mode;
    logic [WIDTH-1:0] w_q;

    assign w_mode = mode_t'(i_mode);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            logic w_from_lo;
            logic w_from_hi;

            if (gi == 0) begin : g_lsb
                assign w_from_lo = i_d;
            end else begin : g_lo
                assign w_from_lo = w_q[gi-1];
            end

            if (gi == WIDTH - 1) begin : g_msb
                assign w_from_hi = i_d;
            end else begin : g_hi
                assign w_from_hi = w_q[gi+1];
            end

            shift_reg_cell u_cell (
                .i_clk     (i_clk),
                .i_rst     (i_rst),
                .i_en      (i_en),
                .i_mode    (w_mode),
                .i_from_lo (w_from_lo),
                .i_from_hi (w_from_hi),
                .i_p       (i_p[gi]),
                .o_q       (w_q[gi])
            );
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_dir_q;
    logic             w_dir_d;
    logic             r_vld_q;
    logic             w_vld_d;
    logic             w_shift;
    logic             w_shift_dir;

    assign w_shift     = i_en && ((w_mode == MODE_SHL) || (w_mode == MODE_SHR));
    assign w_shift_dir = (w_mode == MODE_SHR) ? c_DIR_RIGHT : c_DIR_LEFT;

    // A direction change restarts the word with the incoming bit as shift 1.
    always_comb begin
        w_cnt_d = r_cnt_q;
        w_dir_d = r_dir_q;
        w_vld_d = 1'b0;
        if (i_en && (w_mode == MODE_LOAD)) begin
            w_cnt_d = '0;
        end else if (w_shift) begin
            if (w_shift_dir != r_dir_q) begin
                w_cnt_d = c_CNT_ONE;
                w_dir_d = w_shift_dir;
            end else if (r_cnt_q == c_CNT_LAST) begin
                w_cnt_d = '0;
                w_vld_d = 1'b1;
            end else begin
                w_cnt_d = r_cnt_q + c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt_q <= '0;
            r_dir_q <= c_DIR_LEFT;
            r_vld_q <= 1'b0;
        end else begin
            r_cnt_q <= w_cnt_d;
            r_dir_q <= w_dir_d;
            r_vld_q <= w_vld_d;
        end
    end

    assign o_q        = w_q;
    assign o_sout_l   = w_q[WIDTH-1];
    assign o_sout_r   = w_q[0];
    assign o_cnt      = r_cnt_q;
    assign o_word_vld = r_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_univ.sv
// ============================================================================
// Module      : tb_shift_reg_univ
// Description : Directed self-checking bench for shift_reg_univ (WIDTH 4 and 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_reg_univ;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       d;
    logic [3:0] p4;
    logic [7:0] p8;

    logic [3:0] q4;
    logic       sl4, sr4, vld4;
    logic [1:0] cnt4;
    logic [7:0] q8;
    logic       sl8, sr8, vld8;
    logic [2:0] cnt8;

    int n_checks = 0;
    int n_fail   = 0;

    shift_reg_univ #(.WIDTH(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_d(d), .i_p(p4),
        .o_q(q4), .o_sout_l(sl4), .o_sout_r(sr4), .o_cnt(cnt4), .o_word_vld(vld4)
    );

    shift_reg_univ #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_d(d), .i_p(p8),
        .o_q(q8), .o_sout_l(sl8), .o_sout_r(sr8), .o_cnt(cnt8), .o_word_vld(vld8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic din);
        rst  = r;
        en   = e;
        mode = m;
        d    = din;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        p4 = 4'hF;
        p8 = 8'hFF;
        drive(1'b1, 1'b0, 2'b11, 1'b1);
        n_checks++; if (q4 !== 4'b0000) begin n_fail++; $display("FAIL reset_q4: got %b expected 0000", q4); end
        n_checks++; if (cnt4 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt4: got %0d expected 0", cnt4); end
        n_checks++; if (vld4 !== 1'b0) begin n_fail++; $display("FAIL reset_vld4: got %b expected 0", vld4); end
        n_checks++; if (q8 !== 8'h00) begin n_fail++; $display("FAIL reset_q8: got %h expected 00", q8); end
    endtask

    task automatic test_shift_left();
        logic [3:0] exp_q [4];
        logic [1:0] exp_c [4];
        logic       din   [4];
        exp_q = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd0};
        din   = '{1'b1, 1'b0, 1'b1, 1'b1};
        drive(1'b1, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'b01, din[i]);
            n_checks++; if (q4 !== exp_q[i]) begin n_fail++; $display("FAIL shl_q[%0d]: got %b expected %b", i, q4, exp_q[i]); end
            n_checks++; if (cnt4 !== exp_c[i]) begin n_fail++; $display("FAIL shl_cnt[%0d]: got %0d expected %0d", i, cnt4, exp_c[i]); end
            n_checks++; if (vld4 !== (i == 3)) begin n_fail++; $display("FAIL shl_vld[%0d]: got %b expected %b", i, vld4, (i == 3)); end
        end
        n_checks++; if ({sl4, sr4} !== 2'b11) begin n_fail++; $display("FAIL shl_taps: got %b expected 11", {sl4, sr4}); end
    endtask

    task automatic test_load_shift_right();
        p4 = 4'b1010;
        drive(1'b0, 1'b1, 2'b11, 1'b0);
        n_checks++; if (q4 !== 4'b1010) begin n_fail++; $display("FAIL load_q: got %b expected 1010", q4); end
        n_checks++; if (cnt4 !== 2'd0) begin n_fail++; $display("FAIL load_cnt: got %0d expected 0", cnt4); end
        drive(1'b0, 1'b1, 2'b10, 1'b1);
        n_checks++; if (q4 !== 4'b1101) begin n_fail++; $display("FAIL ldshr_q: got %b expected 1101", q4); end
        n_checks++; if (cnt4 !== 2'd1) begin n_fail++; $display("FAIL ldshr_cnt: got %0d expected 1", cnt4); end
        n_checks++; if (sr4 !== 1'b1) begin n_fail++; $display("FAIL ldshr_sout_r: got %b expected 1", sr4); end
        n_checks++; if (sl4 !== 1'b1) begin n_fail++; $display("FAIL ldshr_sout_l: got %b expected 1", sl4); end
        n_checks++; if (vld4 !== 1'b0) begin n_fail++; $display("FAIL ldshr_vld: got %b expected 0", vld4); end
    endtask

    task automatic test_dir_change();
        logic [1:0] m     [3];
        logic [1:0] exp_c [3];
        m     = '{2'b01, 2'b01, 2'b10};
        exp_c = '{2'd1, 2'd2, 2'd1};
        drive(1'b1, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, m[i], 1'b0);
            n_checks++; if (cnt4 !== exp_c[i]) begin n_fail++; $display("FAIL dir_cnt[%0d]: got %0d expected %0d", i, cnt4, exp_c[i]); end
            n_checks++; if (vld4 !== 1'b0) begin n_fail++; $display("FAIL dir_vld[%0d]: got %b expected 0", i, vld4); end
        end
    endtask

    task automatic test_shift_right_word();
        logic [3:0] exp_q [4];
        logic [1:0] exp_c [4];
        exp_q = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd0};
        drive(1'b1, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'b10, 1'b1);
            n_checks++; if (q4 !== exp_q[i]) begin n_fail++; $display("FAIL shr_q[%0d]: got %b expected %b", i, q4, exp_q[i]); end
            n_checks++; if (cnt4 !== exp_c[i]) begin n_fail++; $display("FAIL shr_cnt[%0d]: got %0d expected %0d", i, cnt4, exp_c[i]); end
            n_checks++; if (vld4 !== (i == 3)) begin n_fail++; $display("FAIL shr_vld[%0d]: got %b expected %b", i, vld4, (i == 3)); end
        end
        drive(1'b0, 1'b1, 2'b00, 1'b0);
        n_checks++; if (vld4 !== 1'b0) begin n_fail++; $display("FAIL shr_vld_drop: got %b expected 0", vld4); end
    endtask

    task automatic test_enable_hold();
        drive(1'b1, 1'b1, 2'b00, 1'b0);
        drive(1'b0, 1'b1, 2'b01, 1'b1);
        drive(1'b0, 1'b1, 2'b01, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 2'b01, 1'b0);
            n_checks++; if (q4 !== 4'b0011) begin n_fail++; $display("FAIL en_q[%0d]: got %b expected 0011", i, q4); end
            n_checks++; if (cnt4 !== 2'd2) begin n_fail++; $display("FAIL en_cnt[%0d]: got %0d expected 2", i, cnt4); end
            n_checks++; if (vld4 !== 1'b0) begin n_fail++; $display("FAIL en_vld[%0d]: got %b expected 0", i, vld4); end
        end
        drive(1'b0, 1'b1, 2'b00, 1'b1);
        n_checks++; if ({q4, cnt4} !== {4'b0011, 2'd2}) begin n_fail++; $display("FAIL hold_mode: got %b/%0d expected 0011/2", q4, cnt4); end
        drive(1'b0, 1'b1, 2'b01, 1'b0);
        n_checks++; if ({q4, cnt4, vld4} !== {4'b0110, 2'd3, 1'b0}) begin n_fail++; $display("FAIL resume1: got %b/%0d/%b expected 0110/3/0", q4, cnt4, vld4); end
        drive(1'b0, 1'b1, 2'b01, 1'b1);
        n_checks++; if ({q4, cnt4, vld4} !== {4'b1101, 2'd0, 1'b1}) begin n_fail++; $display("FAIL resume2: got %b/%0d/%b expected 1101/0/1", q4, cnt4, vld4); end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 2'b01, 1'b1);
        n_checks++; if ({q4, cnt4} !== {4'b0111, 2'd3}) begin n_fail++; $display("FAIL prerst: got %b/%0d expected 0111/3", q4, cnt4); end
        p4 = 4'b1111;
        drive(1'b1, 1'b1, 2'b11, 1'b1);
        n_checks++; if ({q4, cnt4, vld4} !== {4'b0000, 2'd0, 1'b0}) begin n_fail++; $display("FAIL rstprio: got %b/%0d/%b expected 0000/0/0", q4, cnt4, vld4); end
        drive(1'b0, 1'b1, 2'b00, 1'b0);
        n_checks++; if ({q4, vld4} !== {4'b0000, 1'b0}) begin n_fail++; $display("FAIL rstprio_after: got %b/%b expected 0000/0", q4, vld4); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        drive(1'b1, 1'b1, 2'b00, 1'b0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 2'b01, (i % 3) == 0);
            if (vld4 === 1'b1) pulses++;
            n_checks++; if (vld4 !== ((i % 4) == 3)) begin n_fail++; $display("FAIL b2b4_vld[%0d]: got %b expected %b", i, vld4, ((i % 4) == 3)); end
        end
        n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL b2b4_pulses: got %0d expected 2", pulses); end
        drive(1'b1, 1'b1, 2'b00, 1'b0);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 2'b01, 1'b1);
            if (vld8 === 1'b1) pulses++;
            n_checks++; if (vld8 !== ((i % 8) == 7)) begin n_fail++; $display("FAIL b2b8_vld[%0d]: got %b expected %b", i, vld8, ((i % 8) == 7)); end
        end
        n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL b2b8_pulses: got %0d expected 2", pulses); end
        n_checks++; if ({q8, cnt8} !== {8'hFF, 3'd0}) begin n_fail++; $display("FAIL b2b8_final: got %h/%0d expected ff/0", q8, cnt8); end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        mode = 2'b00;
        d    = 1'b0;
        p4   = '0;
        p8   = '0;
        test_reset();
        test_shift_left();
        test_load_shift_right();
        test_dir_change();
        test_shift_right_word();
        test_enable_hold();
        test_reset_priority();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
